// File: rtl/mult_sched.sv
// -----------------------------------------------------------------------------
// mult_sched
//
// Shares one radix-8 Booth multiplier between the CPU M-extension path and
// the encryption accelerator. A winner is picked in IDLE (round-robin on a
// tie), its operands are registered onto the multiplier inputs, and the
// multiplier is enabled until it reports finish. The product is captured
// and handed back to the owner with a one-cycle VALID. If finish never
// arrives within TIMEOUT busy cycles, the operation completes with ERR set
// and a zero result.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cpu_req/acc_req             request, held until the matching gnt
//   cpu_oper_a/b, acc_oper_a/b  operands of each requester
//   cpu_fuct3/acc_fuct3         0 = low product word, 1 = high product word
//   cpu_gnt/acc_gnt             one-cycle accept pulse (combinational, IDLE)
//   cpu_valid/acc_valid         one-cycle completion pulse to the owner
//   result, err                 captured product / timeout flag, held
//   busy                        high while an operation is in BUSY or DONE
//   mult_oper_a/b, mult_fuct3   registered operands to the multiplier
//   mult_enable                 multiplier enable, high in BUSY only
//   mult_o, mult_finish         multiplier result and done strobe
// -----------------------------------------------------------------------------
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no operation; arbitrate requests, grant and latch the winner
//  BUSY  | multiplier enabled; wait for finish or timeout
//  DONE  | result/err valid; pulse owner's valid, return to IDLE
//
module mult_sched #(
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic [LENGTH-1:0] cpu_oper_a,
    input  logic [LENGTH-1:0] cpu_oper_b,
    input  logic              cpu_fuct3,
    output logic              cpu_gnt,
    output logic              cpu_valid,

    input  logic              acc_req,
    input  logic [LENGTH-1:0] acc_oper_a,
    input  logic [LENGTH-1:0] acc_oper_b,
    input  logic              acc_fuct3,
    output logic              acc_gnt,
    output logic              acc_valid,

    output logic [LENGTH-1:0] result,
    output logic              err,
    output logic              busy,

    output logic [LENGTH-1:0] mult_oper_a,
    output logic [LENGTH-1:0] mult_oper_b,
    output logic              mult_enable,
    output logic              mult_fuct3,
    input  logic [LENGTH-1:0] mult_o,
    input  logic              mult_finish
);

    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_ACC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            owner;
    logic            last_owner;
    logic [TW-1:0]   tmo_cnt;
    logic            cpu_wins;
    logic            tmo_hit;

    // CPU wins when it is the only requester, or on a tie when the
    // accelerator was served last.
    assign cpu_wins = cpu_req && (!acc_req || (last_owner == OWN_ACC));
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cpu_gnt     = 1'b0;
        acc_gnt     = 1'b0;
        cpu_valid   = 1'b0;
        acc_valid   = 1'b0;
        mult_enable = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_wins) begin
                    cpu_gnt    = 1'b1;
                    next_state = ST_BUSY;
                end else if (acc_req) begin
                    acc_gnt    = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy        = 1'b1;
                mult_enable = 1'b1;
                if (mult_finish || tmo_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                cpu_valid  = (owner == OWN_CPU);
                acc_valid  = (owner == OWN_ACC);
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= OWN_CPU;
            last_owner  <= OWN_ACC;
            tmo_cnt     <= '0;
            result      <= '0;
            err         <= 1'b0;
            mult_oper_a <= '0;
            mult_oper_b <= '0;
            mult_fuct3  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_gnt) begin
                        mult_oper_a <= cpu_oper_a;
                        mult_oper_b <= cpu_oper_b;
                        mult_fuct3  <= cpu_fuct3;
                        owner       <= OWN_CPU;
                        last_owner  <= OWN_CPU;
                        tmo_cnt     <= '0;
                    end else if (acc_gnt) begin
                        mult_oper_a <= acc_oper_a;
                        mult_oper_b <= acc_oper_b;
                        mult_fuct3  <= acc_fuct3;
                        owner       <= OWN_ACC;
                        last_owner  <= OWN_ACC;
                        tmo_cnt     <= '0;
                    end
                end
                ST_BUSY: begin
                    // Finish takes priority over a timeout in the same cycle.
                    if (mult_finish) begin
                        result <= mult_o;
                        err    <= 1'b0;
                    end else if (tmo_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_mult_sched
//
// Directed bench for mult_sched. A small multiplier model computes the
// 64-bit product of the registered operands and asserts finish on a
// selectable BUSY cycle (fin_k; 0 means never). Outputs are sampled on the
// falling clock edge or 1 ns after a combinational input change.
// -----------------------------------------------------------------------------
module tb_mult_sched;

    localparam int LENGTH  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, acc_req;
    logic [LENGTH-1:0] cpu_oper_a, cpu_oper_b, acc_oper_a, acc_oper_b;
    logic              cpu_fuct3, acc_fuct3;
    logic              cpu_gnt, cpu_valid, acc_gnt, acc_valid;
    logic [LENGTH-1:0] result;
    logic              err, busy;
    logic [LENGTH-1:0] mult_oper_a, mult_oper_b, mult_o;
    logic              mult_enable, mult_fuct3, mult_finish;

    int n_vec = 0;
    int n_err = 0;

    mult_sched #(.LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_oper_a  (cpu_oper_a),
        .cpu_oper_b  (cpu_oper_b),
        .cpu_fuct3   (cpu_fuct3),
        .cpu_gnt     (cpu_gnt),
        .cpu_valid   (cpu_valid),
        .acc_req     (acc_req),
        .acc_oper_a  (acc_oper_a),
        .acc_oper_b  (acc_oper_b),
        .acc_fuct3   (acc_fuct3),
        .acc_gnt     (acc_gnt),
        .acc_valid   (acc_valid),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mult_oper_a (mult_oper_a),
        .mult_oper_b (mult_oper_b),
        .mult_enable (mult_enable),
        .mult_fuct3  (mult_fuct3),
        .mult_o      (mult_o),
        .mult_finish (mult_finish)
    );

    always #5 clk = ~clk;

    // multiplier model
    logic [63:0] prod;
    int          fin_k  = 1;
    int          en_cnt = 0;
    assign prod        = {32'b0, mult_oper_a} * {32'b0, mult_oper_b};
    assign mult_o      = mult_fuct3 ? prod[63:32] : prod[31:0];
    assign mult_finish = mult_enable && (fin_k != 0) && (en_cnt == fin_k - 1);
    always @(posedge clk) en_cnt <= mult_enable ? en_cnt + 1 : 0;

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0; acc_req = 1'b0;
        cpu_oper_a = '0; cpu_oper_b = '0; cpu_fuct3 = 1'b0;
        acc_oper_a = '0; acc_oper_b = '0; acc_fuct3 = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, mult_enable, cpu_gnt, acc_gnt, cpu_valid, acc_valid, err, mult_fuct3} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, mult_enable, cpu_gnt, acc_gnt, cpu_valid, acc_valid, err, mult_fuct3});
        end
        n_vec++;
        if (result !== 32'h0) begin
            n_err++; $display("FAIL reset_result: got %h want 0", result);
        end
        n_vec++;
        if ({mult_oper_a, mult_oper_b} !== 64'h0) begin
            n_err++; $display("FAIL reset_oper: got %h/%h want 0/0", mult_oper_a, mult_oper_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_single();
        @(negedge clk);
        fin_k = 1;
        cpu_oper_a = 32'd3; cpu_oper_b = 32'd5; cpu_fuct3 = 1'b0; cpu_req = 1'b1;
        #1;
        n_vec++;
        if ({cpu_gnt, acc_gnt} !== 2'b10) begin
            n_err++; $display("FAIL single_gnt: got cpu/acc %b want 10", {cpu_gnt, acc_gnt});
        end
        @(negedge clk);
        cpu_req = 1'b0;
        n_vec++;
        if ({mult_enable, busy, cpu_valid} !== 3'b110) begin
            n_err++; $display("FAIL single_busy: got en/busy/valid %b want 110", {mult_enable, busy, cpu_valid});
        end
        @(negedge clk);
        n_vec++;
        if ({cpu_valid, acc_valid, mult_enable, err} !== 4'b1000) begin
            n_err++; $display("FAIL single_done: got cv/av/en/err %b want 1000",
                              {cpu_valid, acc_valid, mult_enable, err});
        end
        n_vec++;
        if (result !== 32'd15) begin
            n_err++; $display("FAIL single_result: got %0d want 15", result);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, cpu_valid, acc_valid} !== 3'b000) begin
            n_err++; $display("FAIL single_idle: got busy/cv/av %b want 000", {busy, cpu_valid, acc_valid});
        end
    endtask

    task automatic test_round_robin();
        int          g_who[3];
        int          g_cyc[3];
        int          ng;
        logic [31:0] res[2];
        int          v_who[2];
        int          nv;
        bit          dbl;
        ng = 0; nv = 0; dbl = 1'b0;
        g_who = '{-1, -1, -1}; g_cyc = '{0, 0, 0};
        res = '{32'h0, 32'h0}; v_who = '{-1, -1};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fin_k = 1;
        cpu_oper_a = 32'd7;          cpu_oper_b = 32'd6; cpu_fuct3 = 1'b0;
        acc_oper_a = 32'hFFFF_FFFF;  acc_oper_b = 32'd2; acc_fuct3 = 1'b0;
        cpu_req = 1'b1; acc_req = 1'b1;
        for (int c = 0; c < 20 && ng < 3; c++) begin
            #1;
            if (cpu_gnt && acc_gnt) dbl = 1'b1;
            if (cpu_gnt) begin g_who[ng] = 0; g_cyc[ng] = c; ng++; end
            else if (acc_gnt) begin g_who[ng] = 1; g_cyc[ng] = c; ng++; end
            if ((cpu_valid || acc_valid) && nv < 2) begin
                res[nv] = result; v_who[nv] = acc_valid ? 1 : 0; nv++;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0; acc_req = 1'b0;
        n_vec++;
        if (dbl !== 1'b0) begin
            n_err++; $display("FAIL rr_double_gnt: got %b want 0", dbl);
        end
        n_vec++;
        if (g_who[0] != 0 || g_who[1] != 1 || g_who[2] != 0) begin
            n_err++; $display("FAIL rr_order: got %0d,%0d,%0d want 0,1,0", g_who[0], g_who[1], g_who[2]);
        end
        n_vec++;
        if (g_cyc[1] - g_cyc[0] != 3) begin
            n_err++; $display("FAIL rr_throughput: got gap %0d want 3", g_cyc[1] - g_cyc[0]);
        end
        n_vec++;
        if (res[0] !== 32'd42 || v_who[0] != 0) begin
            n_err++; $display("FAIL rr_first: got %h owner %0d want 0000002a owner 0", res[0], v_who[0]);
        end
        n_vec++;
        if (res[1] !== 32'hFFFF_FFFE || v_who[1] != 1) begin
            n_err++; $display("FAIL rr_second: got %h owner %0d want fffffffe owner 1", res[1], v_who[1]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_high_word();
        @(negedge clk);
        fin_k = 1;
        acc_oper_a = 32'h0001_0000; acc_oper_b = 32'h0001_0000; acc_fuct3 = 1'b1; acc_req = 1'b1;
        #1;
        n_vec++;
        if ({cpu_gnt, acc_gnt} !== 2'b01) begin
            n_err++; $display("FAIL hw_gnt: got cpu/acc %b want 01", {cpu_gnt, acc_gnt});
        end
        @(negedge clk);
        acc_req = 1'b0;
        n_vec++;
        if ({mult_enable, mult_fuct3} !== 2'b11) begin
            n_err++; $display("FAIL hw_fuct3: got en/fuct3 %b want 11", {mult_enable, mult_fuct3});
        end
        @(negedge clk);
        n_vec++;
        if ({acc_valid, cpu_valid} !== 2'b10 || result !== 32'h1) begin
            n_err++; $display("FAIL hw_result: got av/cv %b res %h want 10 res 00000001",
                              {acc_valid, cpu_valid}, result);
        end
        @(negedge clk);
        acc_fuct3 = 1'b0;
    endtask

    task automatic test_timeout();
        int lat;
        int en_cycles;
        @(negedge clk);
        fin_k = 0;
        cpu_oper_a = 32'd9; cpu_oper_b = 32'd9; cpu_fuct3 = 1'b0; cpu_req = 1'b1;
        #1;
        n_vec++;
        if (cpu_gnt !== 1'b1) begin
            n_err++; $display("FAIL tmo_gnt: got %b want 1", cpu_gnt);
        end
        lat = -1; en_cycles = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) cpu_req = 1'b0;
            if (mult_enable) en_cycles++;
            if (cpu_valid) begin lat = c; break; end
        end
        n_vec++;
        if (lat != TIMEOUT + 1 || en_cycles != TIMEOUT) begin
            n_err++; $display("FAIL tmo_latency: got lat %0d busy %0d want %0d/%0d",
                              lat, en_cycles, TIMEOUT + 1, TIMEOUT);
        end
        n_vec++;
        if (err !== 1'b1 || result !== 32'h0) begin
            n_err++; $display("FAIL tmo_err: got err %b res %h want 1/00000000", err, result);
        end
        @(negedge clk);
        fin_k = 1;
        acc_oper_a = 32'd4; acc_oper_b = 32'd4; acc_req = 1'b1;
        #1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) acc_req = 1'b0;
            if (acc_valid) begin lat = c; break; end
        end
        n_vec++;
        if (lat != 2 || err !== 1'b0 || result !== 32'd16) begin
            n_err++; $display("FAIL tmo_recover: got lat %0d err %b res %0d want 2/0/16", lat, err, result);
        end
        @(negedge clk);
    endtask

    task automatic test_delayed_finish();
        int lat;
        bit stable;
        @(negedge clk);
        fin_k = 3;
        cpu_oper_a = 32'h1234; cpu_oper_b = 32'h10; cpu_fuct3 = 1'b0; cpu_req = 1'b1;
        #1;
        lat = -1; stable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cpu_req = 1'b0; cpu_oper_a = 32'hDEAD_BEEF; cpu_oper_b = 32'h5; cpu_fuct3 = 1'b1;
            end
            if (mult_enable && (mult_oper_a !== 32'h1234 || mult_oper_b !== 32'h10 || mult_fuct3 !== 1'b0))
                stable = 1'b0;
            if (cpu_valid) begin lat = c; break; end
        end
        n_vec++;
        if (lat != 4) begin
            n_err++; $display("FAIL delay_latency: got %0d want 4", lat);
        end
        n_vec++;
        if (stable !== 1'b1) begin
            n_err++; $display("FAIL delay_stable: got %b want 1", stable);
        end
        n_vec++;
        if (result !== 32'h12340 || err !== 1'b0) begin
            n_err++; $display("FAIL delay_result: got %h err %b want 00012340 err 0", result, err);
        end
        cpu_fuct3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit saw_valid;
        @(negedge clk);
        fin_k = 0;
        cpu_oper_a = 32'd5; cpu_oper_b = 32'd5; cpu_req = 1'b1;
        #1;
        n_vec++;
        if (cpu_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_gnt: got %b want 1", cpu_gnt);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mult_enable, busy, err} !== 3'b000 || result !== 32'h0 || mult_oper_a !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_clear: got en/busy/err %b res %h opa %h want 000/0/0",
                              {mult_enable, busy, err}, result, mult_oper_a);
        end
        saw_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_valid || acc_valid) saw_valid = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (cpu_valid || acc_valid) saw_valid = 1'b1;
        end
        n_vec++;
        if (saw_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_valid: got %b want 0", saw_valid);
        end
        fin_k = 1;
        cpu_req = 1'b1; acc_req = 1'b1;
        #1;
        n_vec++;
        if ({cpu_gnt, acc_gnt} !== 2'b10) begin
            n_err++; $display("FAIL rst_mid_tie: got cpu/acc %b want 10", {cpu_gnt, acc_gnt});
        end
        @(negedge clk);
        cpu_req = 1'b0; acc_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_single();
        test_round_robin();
        test_high_word();
        test_timeout();
        test_delayed_finish();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Sequencing and arbitration controller for the radix-8 Booth multiplier datapath (`mult_radix8_top`). It shares one multiplier instance between two requesters: the RV32IM core's M-extension path (CPU) and the encryption accelerator (ACC). It registers the winning requester's operands and drives ENABLE_MULT/FUCT3 for the duration of the operation. It then captures MULT_O on MULT_FINISH and returns the result to the owner, with a timeout guard for a missing finish.

## Interface
- LENGTH, 32, operand/result width
- TIMEOUT, 8, max BUSY cycles without MULT_FINISH before error completion (≥2)

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- CPU_REQ  in  1  CPU request; held high, operands stable, until CPU_GNT
- CPU_OPER_A, CPU_OPER_B  in  LENGTH  CPU operands
- CPU_FUCT3  in  1  CPU op select (0 low word, 1 high word), passed to multiplier
- CPU_GNT  out  1  one-cycle accept pulse
- CPU_VALID  out  1  one-cycle completion pulse
- ACC_REQ, ACC_OPER_A, ACC_OPER_B, ACC_FUCT3, ACC_GNT, ACC_VALID: same as CPU_* for the accelerator
- RESULT  out  LENGTH  captured product, held until next completion
- ERR  out  1  set with VALID when completion was by timeout
- BUSY  out  1  high in BUSY and DONE
- MULT_OPER_A, MULT_OPER_B  out  LENGTH  registered operands to multiplier
- MULT_ENABLE  out  1  to ENABLE_MULT
- MULT_FUCT3  out  1  to FUCT3
- MULT_O  in  LENGTH  multiplier result
- MULT_FINISH  in  1  multiplier done

## Operation
- States: IDLE, BUSY, DONE. Reset state: IDLE.
- **IDLE**
  - If any REQ is high, pick a winner:
    - only one requests: that one wins;
    - both request: the one not in LAST_OWNER wins.
  - Assert the winner's GNT combinationally in this cycle.
  - At the clock edge: latch the winner's OPER_A/OPER_B/FUCT3 into the MULT_* registers, set OWNER, set LAST_OWNER=OWNER, clear TMO_CNT, go to BUSY.
  - GNT is never asserted outside IDLE, and never to both requesters in the same cycle.
- **BUSY**
  - MULT_ENABLE=1. MULT_OPER_*/MULT_FUCT3 held constant.
  - If MULT_FINISH=1: RESULT<=MULT_O, ERR<=0, go to DONE.
  - Else if TMO_CNT==TIMEOUT-1: RESULT<=0, ERR<=1, go to DONE.
  - Else TMO_CNT++.
- **DONE**
  - MULT_ENABLE=0. The VALID of OWNER is 1 for this single cycle. Go to IDLE.
- LAST_OWNER resets to ACC, so the CPU wins the first tie after reset.
- MULT_OPER_*/MULT_FUCT3 keep their last value in IDLE; they are not cleared.
- RESULT and ERR hold until the next DONE.
- TMO_CNT is $clog2(TIMEOUT) bits and does not wrap; the exit is taken before any overflow.
- MULT_FINISH is ignored outside BUSY.
- A requester may drop REQ only after its GNT; dropping REQ earlier simply withdraws the request.
- Reset values of all outputs are 0: RESULT, ERR, MULT_OPER_*, MULT_FUCT3, MULT_ENABLE, GNTs, VALIDs, BUSY.

## Timing
- Accept in cycle N (GNT=1).
- MULT_ENABLE=1 from cycle N+1.
- A combinational multiplier (MULT_FINISH in the first enable cycle) gives RESULT valid and VALID=1 in cycle N+2.
- The earliest next GNT is cycle N+3, so throughput is one operation per 3 cycles.
- With finish in the k-th BUSY cycle (k=1..TIMEOUT), VALID is at N+1+k.
- With no finish, ERR/VALID is at N+1+TIMEOUT.
- Asserting RST_N low mid-operation immediately forces IDLE and drops MULT_ENABLE. The in-flight operation is discarded with no VALID, and LAST_OWNER returns to ACC.
- A REQ that rises during BUSY/DONE waits and is considered in the next IDLE cycle.

## Test plan
- **CPU single multiply:** CPU_REQ with A=3, B=5, FUCT3=0, cycle N → CPU_GNT@N, MULT_ENABLE@N+1, CPU_VALID@N+2, RESULT=15, ERR=0, ACC_VALID never asserted.
- **Round-robin:** after reset, both REQ held high with CPU(7×6) and ACC(0xFFFFFFFF×2) → CPU served first (RESULT=42), ACC second (RESULT=0xFFFFFFFE); the third tie goes to CPU. There are no double grants.
- **High word:** ACC FUCT3=1 with 0x00010000×0x00010000 → MULT_FUCT3=1 during BUSY, ACC_VALID with RESULT=0x00000001.
- **Timeout:** MULT_FINISH forced 0 → VALID exactly TIMEOUT(8) BUSY cycles later with ERR=1 and RESULT=0; the next request completes normally with ERR=0.
- **Delayed finish:** a model asserts MULT_FINISH on the 3rd BUSY cycle → VALID@N+4, and the operands stay stable throughout BUSY.
- **Reset mid-operation:** RST_N low during BUSY → MULT_ENABLE, BUSY, and all outputs 0 immediately, with no VALID. After release, a tie is granted to CPU.
